// File: rtl/enemy_wave_control.sv
// Multi-slot enemy controller: per-slot IDLE/UPDATE/WAIT/EXPLODE FSMs, frame-tick spawn scheduler,
// saturating kill/escape counters. Optional escape-limit game-over latch: define ENEMY_ESCAPE_LIMIT_EN.

module enemy_wave_control #(
    parameter int unsigned N_ENEMIES      = 4,
    parameter int unsigned SPAWN_GAP      = 60,
    parameter int unsigned EXPLODE_FRAMES = 8,
    parameter int unsigned CNT_W          = 8,
    parameter int unsigned ESCAPE_LIMIT   = 5
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 enable,
    input  logic                 frameTick,
    input  logic [N_ENEMIES-1:0] bottomReached,
    input  logic [N_ENEMIES-1:0] collidedWithBullet,
    output logic [N_ENEMIES-1:0] inResetState,
    output logic [N_ENEMIES-1:0] inUpdatePositionStateE,
    output logic [N_ENEMIES-1:0] inExplodeState,
    output logic [N_ENEMIES-1:0] activeMask,
    output logic [CNT_W-1:0]     killCount,
    output logic [CNT_W-1:0]     escapedCount,
    output logic                 gameOver
);

    localparam int unsigned SPAWN_W = $clog2(SPAWN_GAP) + 1;
    localparam int unsigned EXP_W   = $clog2(EXPLODE_FRAMES) + 1;
    localparam int unsigned POP_W   = $clog2(N_ENEMIES + 1);
    localparam int unsigned ACC_W   = CNT_W + POP_W;

    localparam logic [SPAWN_W-1:0] SPAWN_TERM = SPAWN_W'(SPAWN_GAP - 1);
    localparam logic [EXP_W-1:0]   EXP_LOAD   = EXP_W'(EXPLODE_FRAMES - 1);
    localparam logic [ACC_W-1:0]   CNT_MAX    = (ACC_W'(1) << CNT_W) - ACC_W'(1);

    if (N_ENEMIES < 1 || N_ENEMIES > 16 || SPAWN_GAP < 1 || EXPLODE_FRAMES < 1 ||
        CNT_W < 1 || ESCAPE_LIMIT < 1) begin : g_bad_params
        $error("enemy_wave_control: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_UPDATE  = 2'd1,
        S_WAIT    = 2'd2,
        S_EXPLODE = 2'd3
    } slot_state_t;

    slot_state_t          state_q [N_ENEMIES];
    slot_state_t          state_d [N_ENEMIES];
    logic [EXP_W-1:0]     boom_q  [N_ENEMIES];
    logic [EXP_W-1:0]     boom_d  [N_ENEMIES];
    logic [SPAWN_W-1:0]   spawn_q;
    logic [SPAWN_W-1:0]   spawn_d;
    logic [N_ENEMIES-1:0] spawn_sel;
    logic [N_ENEMIES-1:0] kill_ev;
    logic [N_ENEMIES-1:0] esc_ev;
    logic                 any_idle;
    logic                 tick;
    logic                 at_term;
    logic                 spawn_go;
    logic                 halt;
    logic [POP_W-1:0]     kill_pop;
    logic [POP_W-1:0]     esc_pop;
    logic [ACC_W-1:0]     kill_sum;
    logic [ACC_W-1:0]     esc_sum;
    logic [CNT_W-1:0]     kill_d;
    logic [CNT_W-1:0]     esc_d;

`ifdef ENEMY_ESCAPE_LIMIT_EN
    logic game_over_q;

    // Sticky; set one cycle after the escape count reaches the limit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            game_over_q <= 1'b0;
        end else if (escapedCount >= CNT_W'(ESCAPE_LIMIT)) begin
            game_over_q <= 1'b1;
        end
    end

    assign halt     = game_over_q;
    assign gameOver = game_over_q;
`else
    assign halt     = 1'b0;
    assign gameOver = 1'b0;
`endif

    assign tick     = enable & frameTick;
    assign at_term  = (spawn_q == SPAWN_TERM);
    assign spawn_go = enable & at_term & any_idle & ~halt;

    // Lowest-index IDLE slot, judged on registered state so a slot freed this cycle waits one cycle.
    always_comb begin
        spawn_sel = '0;
        any_idle  = 1'b0;
        for (int i = 0; i < N_ENEMIES; i++) begin
            if (!any_idle && state_q[i] == S_IDLE) begin
                spawn_sel[i] = 1'b1;
                any_idle     = 1'b1;
            end
        end
    end

    always_comb begin
        spawn_d = spawn_q;
        if (spawn_go) begin
            spawn_d = '0;
        end else if (tick && !at_term) begin
            spawn_d = spawn_q + SPAWN_W'(1);
        end
    end

    // Per-slot next state; hits outrank bottom escapes and the game-over drain.
    always_comb begin
        kill_ev = '0;
        esc_ev  = '0;
        for (int i = 0; i < N_ENEMIES; i++) begin
            state_d[i] = state_q[i];
            boom_d[i]  = boom_q[i];
            case (state_q[i])
                S_IDLE: begin
                    if (spawn_go && spawn_sel[i]) state_d[i] = S_UPDATE;
                end
                S_UPDATE: begin
                    if (collidedWithBullet[i]) begin
                        state_d[i] = S_EXPLODE;
                        boom_d[i]  = EXP_LOAD;
                        kill_ev[i] = 1'b1;
                    end else if (bottomReached[i]) begin
                        state_d[i] = S_IDLE;
                        esc_ev[i]  = 1'b1;
                    end else begin
                        state_d[i] = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (collidedWithBullet[i]) begin
                        state_d[i] = S_EXPLODE;
                        boom_d[i]  = EXP_LOAD;
                        kill_ev[i] = 1'b1;
                    end else if (halt) begin
                        state_d[i] = S_IDLE;
                    end else if (tick) begin
                        state_d[i] = S_UPDATE;
                    end
                end
                S_EXPLODE: begin
                    if (tick) begin
                        if (boom_q[i] == '0) state_d[i] = S_IDLE;
                        else                 boom_d[i]  = boom_q[i] - EXP_W'(1);
                    end
                end
                default: state_d[i] = S_IDLE;
            endcase
        end
    end

    always_comb begin
        kill_pop = '0;
        esc_pop  = '0;
        for (int i = 0; i < N_ENEMIES; i++) begin
            kill_pop = kill_pop + POP_W'(kill_ev[i]);
            esc_pop  = esc_pop + POP_W'(esc_ev[i]);
        end
    end

    assign kill_sum = ACC_W'(killCount) + ACC_W'(kill_pop);
    assign esc_sum  = ACC_W'(escapedCount) + ACC_W'(esc_pop);
    assign kill_d   = (kill_sum > CNT_MAX) ? {CNT_W{1'b1}} : kill_sum[CNT_W-1:0];
    assign esc_d    = (esc_sum > CNT_MAX) ? {CNT_W{1'b1}} : esc_sum[CNT_W-1:0];

    // State, counters and Moore outputs registered together so outputs track state exactly.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < N_ENEMIES; i++) begin
                state_q[i] <= S_IDLE;
                boom_q[i]  <= '0;
            end
            spawn_q                <= '0;
            killCount              <= '0;
            escapedCount           <= '0;
            inResetState           <= '1;
            inUpdatePositionStateE <= '0;
            inExplodeState         <= '0;
            activeMask             <= '0;
        end else begin
            for (int i = 0; i < N_ENEMIES; i++) begin
                state_q[i]                <= state_d[i];
                boom_q[i]                 <= boom_d[i];
                inResetState[i]           <= (state_d[i] == S_IDLE);
                inUpdatePositionStateE[i] <= (state_d[i] == S_UPDATE);
                inExplodeState[i]         <= (state_d[i] == S_EXPLODE);
                activeMask[i]             <= (state_d[i] == S_UPDATE) || (state_d[i] == S_WAIT);
            end
            spawn_q      <= spawn_d;
            killCount    <= kill_d;
            escapedCount <= esc_d;
        end
    end

endmodule
